adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_pkg.sv | 18 +
 rtl/add8_pipe.sv | 53 +++++
 rtl/adder_arbiter.sv | 107 ++++++++++
 tb/tb_adder_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and widths for the arbitrated adder: operand width, counter
// width, requester tag and the record that enters the adder pipeline.
package adder_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    typedef logic tag_t;

    typedef struct packed {
        logic              valid;
        tag_t              tag;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
    } stage_t;

endpackage

// File: rtl/add8_pipe.sv
// LAT-stage pipelined 8-bit adder; valid and requester tag travel with each
// result so the caller can route it without tracking latency itself.
module add8_pipe
    import adder_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  stage_t            in_stage,
    output logic              out_valid,
    output tag_t              out_tag,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout
);

    logic              vld_p [LAT];
    tag_t              tag_p [LAT];
    logic [DATA_W:0]   res_p [LAT];

    function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic              cin);
        return {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= in_stage.valid;
            for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Stage p0 captures the sum only on an accepting edge; later stages just delay it
    always_ff @(posedge clk) begin
        if (in_stage.valid) begin
            tag_p[0] <= in_stage.tag;
            res_p[0] <= add_carry(in_stage.a, in_stage.b, in_stage.cin);
        end
        for (int i = 1; i < LAT; i++) begin
            tag_p[i] <= tag_p[i-1];
            res_p[i] <= res_p[i-1];
        end
    end

    assign out_valid = vld_p[LAT-1];
    assign out_tag   = tag_p[LAT-1];
    assign out_sum   = res_p[LAT-1][DATA_W-1:0];
    assign out_cout  = res_p[LAT-1][DATA_W];

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one pipelined adder: round-robin grant, issue counter,
// and per-requester result strobes with held last results.
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_cin,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_cin,
    output logic              req1_ready,
    output logic              res0_valid,
    output logic [DATA_W-1:0] res0_sum,
    output logic              res0_cout,
    output logic              res1_valid,
    output logic [DATA_W-1:0] res1_sum,
    output logic              res1_cout,
    output logic [CNT_W-1:0]  issue_cnt
);

    logic              prio;
    logic              grant0;
    logic              grant1;
    stage_t            in_stage;
    logic              out_valid;
    tag_t              out_tag;
    logic [DATA_W-1:0] out_sum;
    logic              out_cout;
    logic [DATA_W-1:0] hold0_sum;
    logic [DATA_W-1:0] hold1_sum;
    logic              hold0_cout;
    logic              hold1_cout;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || !prio)) grant0 = 1'b1;
            else if (req1_valid)                      grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        in_stage.valid = grant0 | grant1;
        in_stage.tag   = grant1;
        in_stage.a     = grant1 ? req1_a   : req0_a;
        in_stage.b     = grant1 ? req1_b   : req0_b;
        in_stage.cin   = grant1 ? req1_cin : req0_cin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio      <= 1'b0;
            issue_cnt <= '0;
        end else if (grant0 || grant1) begin
            prio      <= grant0;
            issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

    add8_pipe #(.LAT(LAT)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_stage  (in_stage),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    // Results present the live pipe value on the strobe and the held copy otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            hold0_sum  <= '0;
            hold0_cout <= 1'b0;
            hold1_sum  <= '0;
            hold1_cout <= 1'b0;
        end else if (out_valid) begin
            if (out_tag) begin
                hold1_sum  <= out_sum;
                hold1_cout <= out_cout;
            end else begin
                hold0_sum  <= out_sum;
                hold0_cout <= out_cout;
            end
        end
    end

    assign res0_valid = out_valid && !out_tag && !rst;
    assign res1_valid = out_valid &&  out_tag && !rst;
    assign res0_sum   = res0_valid ? out_sum  : hold0_sum;
    assign res0_cout  = res0_valid ? out_cout : hold0_cout;
    assign res1_sum   = res1_valid ? out_sum  : hold1_sum;
    assign res1_cout  = res1_valid ? out_cout : hold1_cout;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized and directed bench for adder_arbiter against a queue-based
// reference model of grants, latencies, held results and the issue counter.
module tb_adder_arbiter;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_cin, req1_cin;
    logic       req0_ready, req1_ready;
    logic       res0_valid, res1_valid;
    logic [7:0] res0_sum, res1_sum;
    logic       res0_cout, res1_cout;
    logic [15:0] issue_cnt;

    always #5 clk = ~clk;

    adder_arbiter #(.LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .req1_ready (req1_ready),
        .res0_valid (res0_valid),
        .res0_sum   (res0_sum),
        .res0_cout  (res0_cout),
        .res1_valid (res1_valid),
        .res1_sum   (res1_sum),
        .res1_cout  (res1_cout),
        .issue_cnt  (issue_cnt)
    );

    typedef struct {
        int         due;
        logic       tag;
        logic [8:0] res;
    } pend_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          known   = 0;
    pend_t       pend[$];
    logic        m_prio;
    logic [15:0] m_cnt;
    logic [7:0]  m_sum [2];
    logic        m_cout [2];
    logic        m_g0, m_g1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic c0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic c1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic tick();
        logic       g0, g1, hit0, hit1;
        logic [8:0] r0, r1;
        pend_t      p;
        #1;
        g0 = !rst && req0_valid && (!req1_valid || m_prio == 1'b0);
        g1 = !rst && req1_valid && !g0;
        if (known) begin
            hit0 = 1'b0; hit1 = 1'b0; r0 = '0; r1 = '0;
            foreach (pend[i]) begin
                if (pend[i].due == cyc && !rst) begin
                    if (pend[i].tag) begin hit1 = 1'b1; r1 = pend[i].res; end
                    else             begin hit0 = 1'b1; r0 = pend[i].res; end
                end
            end
            if (hit0) begin m_sum[0] = r0[7:0]; m_cout[0] = r0[8]; end
            if (hit1) begin m_sum[1] = r1[7:0]; m_cout[1] = r1[8]; end
            check("req0_ready", 32'(req0_ready), 32'(g0));
            check("req1_ready", 32'(req1_ready), 32'(g1));
            check("res0_valid", 32'(res0_valid), 32'(hit0));
            check("res1_valid", 32'(res1_valid), 32'(hit1));
            check("res0_sum",   32'(res0_sum),   32'(m_sum[0]));
            check("res0_cout",  32'(res0_cout),  32'(m_cout[0]));
            check("res1_sum",   32'(res1_sum),   32'(m_sum[1]));
            check("res1_cout",  32'(res1_cout),  32'(m_cout[1]));
            check("issue_cnt",  32'(issue_cnt),  32'(m_cnt));
        end
        m_g0 = g0;
        m_g1 = g1;
        @(posedge clk);
        if (rst) begin
            known = 1;
            m_prio = 1'b0;
            m_cnt = '0;
            m_sum[0] = '0; m_sum[1] = '0;
            m_cout[0] = 1'b0; m_cout[1] = 1'b0;
            pend.delete();
        end else if (known && (g0 || g1)) begin
            p.due = cyc + LAT;
            p.tag = g1;
            p.res = g1 ? 9'(req1_a) + 9'(req1_b) + 9'(req1_cin)
                       : 9'(req0_a) + 9'(req0_b) + 9'(req0_cin);
            pend.push_back(p);
            m_cnt = m_cnt + 16'd1;
            m_prio = g0;
        end
        cyc++;
        pend = pend.find(x) with (x.due >= cyc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       v0, v1;
        logic [7:0] a0, b0, a1, b1;
        logic       c0, c1;

        rst = 1'b1;
        m_prio = 1'b0; m_cnt = '0; m_g0 = 1'b0; m_g1 = 1'b0;
        m_sum[0] = '0; m_sum[1] = '0; m_cout[0] = 1'b0; m_cout[1] = 1'b0;
        drive(1, 8'h11, 8'h22, 1, 1, 8'h33, 8'h44, 0);
        @(negedge clk);

        // reset held with both requesters asking
        for (int i = 0; i < 3; i++) tick();
        check("rst_cnt", 32'(issue_cnt), 32'h0);
        check("rst_sum0", 32'(res0_sum), 32'h0);

        // single requester, first edge after release accepts
        rst = 1'b0;
        drive(1, 8'h01, 8'h02, 1, 0, 0, 0, 0);
        tick();
        idle(LAT + 1);
        check("single_sum", 32'(res0_sum), 32'h04);
        check("single_cout", 32'(res0_cout), 32'h0);

        // contention from a fresh pointer
        rst = 1'b1; idle(1); rst = 1'b0;
        drive(1, 8'h03, 8'h04, 0, 1, 8'h05, 8'h06, 1);
        for (int i = 0; i < 4; i++) tick();
        idle(LAT + 1);
        check("cont_cnt", 32'(issue_cnt), 32'd4);
        check("cont_sum0", 32'(res0_sum), 32'h07);
        check("cont_sum1", 32'(res1_sum), 32'h0C);

        // carry-out boundaries
        drive(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1);
        tick();
        drive(0, 0, 0, 0, 1, 8'hFF, 8'hFF, 1);
        tick();
        idle(LAT + 1);
        check("ovf_sum1", 32'(res1_sum), 32'hFF);
        check("ovf_cout1", 32'(res1_cout), 32'h1);

        // reset lands on the edge before the result would appear
        drive(1, 8'h08, 8'h07, 1, 0, 0, 0, 0);
        tick();
        idle(LAT - 2 > 0 ? LAT - 2 : 0);
        rst = 1'b1; idle(1); rst = 1'b0;
        idle(LAT + 1);
        drive(1, 8'h10, 8'h20, 0, 0, 0, 0, 0);
        tick();
        idle(LAT + 1);
        check("post_rst_sum", 32'(res0_sum), 32'h30);

        // random traffic; a stalled requester keeps its operation
        v0 = 0; v1 = 0; a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(v0 && !m_g0)) begin
                v0 = 1'($urandom_range(0, 1));
                a0 = 8'($urandom); b0 = 8'($urandom); c0 = 1'($urandom);
            end
            if (!(v1 && !m_g1)) begin
                v1 = 1'($urandom_range(0, 1));
                a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom);
            end
            rst = ($urandom_range(0, 39) == 0);
            drive(v0, a0, b0, c0, v1, a1, b1, c1);
            tick();
            if (rst) begin v0 = 0; v1 = 0; end
        end
        rst = 1'b0;
        idle(LAT + 1);

        // counter wrap
        rst = 1'b1; idle(1); rst = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            drive(1, 8'($urandom), 8'($urandom), 1'($urandom), 0, 0, 0, 0);
            tick();
        end
        check("cnt_max", 32'(issue_cnt), 32'hFFFF);
        drive(1, 8'h01, 8'h01, 0, 0, 0, 0, 0);
        tick();
        check("cnt_wrap", 32'(issue_cnt), 32'h0000);
        idle(LAT + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
